// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity mode codes and default divisor width.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEF_DIV_WIDTH = 16;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Bundle between the TX FIFO / register block and the serializer.
// master = FIFO and register side, slave = serializer.
interface uart_tx_serializer_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) ();

    logic                  tx_en;
    logic [DIV_WIDTH-1:0]  baud_div;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  txd;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output tx_en, baud_div, fifo_empty, fifo_dout,
        input  fifo_rd_en, txd, busy, tx_done
    );

    modport slave (
        input  tx_en, baud_div, fifo_empty, fifo_dout,
        output fifo_rd_en, txd, busy, tx_done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable bit-clock counter: counts 0..period-1 while enabled and flags the terminal count.
// A load latches a new period (0 treated as 1) and clears the count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] period_in,
    output logic                 tc
);

    logic [DIV_WIDTH-1:0] period_q;
    logic [DIV_WIDTH-1:0] cnt_q;

    // A zero divisor would never reach terminal count, so it is saturated to one clock per bit.
    function automatic logic [DIV_WIDTH-1:0] clamp_period(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    assign tc = en && (cnt_q == (period_q - DIV_WIDTH'(1)));

    // Period latch and wrapping bit-clock counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= DIV_WIDTH'(1);
            cnt_q    <= '0;
        end else if (load) begin
            period_q <= clamp_period(period_in);
            cnt_q    <= '0;
        end else if (en) begin
            cnt_q    <= tc ? '0 : cnt_q + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and sends
// start, DATA_WIDTH data bits LSB first, optional parity and STOP_BITS stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = PAR_NONE,
    parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input logic            clk,
    input logic            rst,
    uart_tx_serializer_if.slave bus
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  busy_q;
    logic                  done_q, done_d;
    logic                  rd_en;
    logic                  tmr_load;
    logic                  tmr_en;
    logic                  tmr_tc;

    assign rd_en    = (state_q == S_IDLE) && bus.tx_en && !bus.fifo_empty && !rst;
    assign tmr_load = (state_q == S_LOAD);
    assign tmr_en   = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);

    uart_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .en        (tmr_en),
        .period_in (bus.baud_div),
        .tc        (tmr_tc)
    );

    // Next-state, shift/parity/index updates and the txd level for the upcoming cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done_d  = 1'b0;
        txd_d   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (rd_en) state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = bus.fifo_dout;
                par_d   = 1'b0;
                idx_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (tmr_tc) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tmr_tc) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tmr_tc) begin
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tmr_tc) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = (PARITY == PAR_EVEN) ? par_d : ~par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    // Data shift register; its contents are don't-care until the next LOAD.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.txd        = txd_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;

endmodule
